// File: rtl/fifo8x9_ctrl.sv
// Write-port arbiter, read gate and occupancy tracker in front of the 8x9 FIFO storage.
// Two requesters share the write port round-robin; one reader; flush clears both pointers.
module fifo8x9_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 9,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req0,
  input  logic [DW-1:0] wr_data0,
  input  logic          wr_req1,
  input  logic [DW-1:0] wr_data1,
  output logic          wr_gnt0,
  output logic          wr_gnt1,
  input  logic          rd_req,
  output logic          rd_gnt,
  output logic          rd_valid,
  input  logic          flush,
  output logic          wren,
  output logic          rden,
  output logic [DW-1:0] fifo_din,
  output logic          WrPtrClr,
  output logic          RdPtrClr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          prio_q, prio_d;
  logic          rd_valid_q;
  logic          run_ok, wr_ok;

  // Grants are zero-latency; reset suppresses them even if the state is still RUN.
  always_comb begin
    run_ok   = !rst && (state_q == StRun) && !flush;
    wr_ok    = run_ok && (count_q < DepthC);
    wr_gnt0  = wr_ok && wr_req0 && (!wr_req1 || !prio_q);
    wr_gnt1  = wr_ok && wr_req1 && (!wr_req0 || prio_q);
    rd_gnt   = run_ok && rd_req && (count_q != '0);
    wren     = wr_gnt0 | wr_gnt1;
    rden     = rd_gnt;
    fifo_din = '0;
    if (wr_gnt0) begin
      fifo_din = wr_data0;
    end else if (wr_gnt1) begin
      fifo_din = wr_data1;
    end
    WrPtrClr = (state_q != StRun);
    RdPtrClr = (state_q != StRun);
    count    = count_q;
    full     = !rst && (count_q == DepthC);
    empty    = rst || (count_q == '0);
    rd_valid = rd_valid_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prio_d  = prio_q;
    unique case (state_q)
      StInit, StFlush: begin
        state_d = StRun;
        count_d = '0;
      end
      StRun: begin
        // Count drops at the flush edge so the FLUSH cycle already reports empty.
        if (flush) begin
          state_d = StFlush;
          count_d = '0;
        end else if (wren && !rden) begin
          count_d = count_q + CW'(1);
        end else if (rden && !wren) begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = StInit;
    endcase
    // Winner loses priority to the other side.
    if (wren) begin
      prio_d = wr_gnt0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      count_q    <= '0;
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      rd_valid_q <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Self-checking bench for fifo8x9_ctrl: cycle model predicts grants/occupancy, and a
// scoreboard queue holds the write data expected on fifo_din.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [8:0] wr_data0 = '0, wr_data1 = '0;
  logic       wr_gnt0, wr_gnt1, rd_gnt, rd_valid, wren, rden, WrPtrClr, RdPtrClr, full, empty;
  logic [8:0] fifo_din;
  logic [3:0] count;

  fifo8x9_ctrl #(.DEPTH(8), .DW(9), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .wr_req0(wr_req0), .wr_data0(wr_data0), .wr_req1(wr_req1), .wr_data1(wr_data1),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .flush(flush), .wren(wren), .rden(rden), .fifo_din(fifo_din),
    .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int   m_state = 0;  // 0 init, 1 run, 2 flush
  int   m_count = 0;
  logic m_prio  = 1'b0;
  logic m_rv    = 1'b0;

  // Expectations for the current cycle.
  logic e_g0, e_g1, e_rd, e_clr, e_full, e_empty, e_rv;
  int   e_count;

  logic [8:0] wq[$];
  logic [8:0] exp_din;

  // Drives one cycle of stimulus after the rising edge and returns at the falling edge,
  // with e_* holding this cycle's expectations and the model advanced to the next cycle.
  task automatic step(input logic r0, input logic [8:0] d0, input logic r1,
                      input logic [8:0] d1, input logic rd, input logic fl, input logic rs);
    logic ok;
    @(posedge clk);
    #1;
    wr_req0 = r0; wr_data0 = d0; wr_req1 = r1; wr_data1 = d1;
    rd_req = rd; flush = fl; rst = rs;
    ok      = !rs && (m_state == 1) && !fl;
    e_g0    = ok && (m_count < 8) && r0 && (!r1 || !m_prio);
    e_g1    = ok && (m_count < 8) && r1 && (!r0 || m_prio);
    e_rd    = ok && rd && (m_count > 0);
    e_clr   = (m_state != 1);
    e_count = m_count;
    e_full  = !rs && (m_count == 8);
    e_empty = rs || (m_count == 0);
    e_rv    = m_rv;
    if (e_g0) wq.push_back(d0);
    if (e_g1) wq.push_back(d1);
    @(negedge clk);
    if (rs) begin
      m_state = 0; m_count = 0; m_prio = 1'b0; m_rv = 1'b0;
    end else begin
      m_rv = e_rd;
      if (m_state != 1) begin
        m_state = 1; m_count = 0;
      end else if (fl) begin
        m_state = 2; m_count = 0;
      end else begin
        m_count = m_count + int'(e_g0 | e_g1) - int'(e_rd);
      end
      if (e_g0 | e_g1) m_prio = e_g0;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 9'h1FF, 1'b1, 9'h1FE, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({wr_gnt0, wr_gnt1, rd_gnt, wren, rden} !== 5'b0)
      $display("FAIL reset_grants got=%b want=00000", {wr_gnt0, wr_gnt1, rd_gnt, wren, rden});
    else n_pass++;
    n_checks++;
    if ({empty, full} !== 2'b10) $display("FAIL reset_flags got=%b want=10", {empty, full});
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({WrPtrClr, RdPtrClr} !== 2'b11 || count !== 4'd0)
      $display("FAIL init_clears got=%b cnt=%0d want=11 cnt=0", {WrPtrClr, RdPtrClr}, count);
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({WrPtrClr, RdPtrClr, empty, wren, rden} !== 5'b00100 || count !== 4'd0)
      $display("FAIL run_idle got=%b cnt=%0d want=00100 cnt=0",
               {WrPtrClr, RdPtrClr, empty, wren, rden}, count);
    else n_pass++;
  endtask

  task automatic test_fill_single();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 9'h101 + 9'(i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (wr_gnt0 !== (i < 8) || wren !== (i < 8) || wr_gnt0 !== e_g0)
        $display("FAIL fill_gnt%0d got=%b/%b want=%b", i, wr_gnt0, wren, (i < 8));
      else n_pass++;
      if (wren === 1'b1) begin
        n_checks++;
        exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
        if (fifo_din !== exp_din) $display("FAIL fill_din%0d got=%h want=%h", i, fifo_din, exp_din);
        else n_pass++;
      end
    end
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0)
      $display("FAIL fill_full got cnt=%0d full=%b empty=%b want cnt=8 full=1 empty=0",
               count, full, empty);
    else n_pass++;
  endtask

  task automatic test_alternate();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 9'h0A0 + 9'(i), 1'b1, 9'h1B0 + 9'(i), 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({wr_gnt0, wr_gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || {wr_gnt0, wr_gnt1} !== {e_g0, e_g1})
        $display("FAIL alt_gnt%0d got=%b want=%b", i, {wr_gnt0, wr_gnt1},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      else n_pass++;
      if (wren === 1'b1) begin
        n_checks++;
        exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
        if (fifo_din !== exp_din) $display("FAIL alt_din%0d got=%h want=%h", i, fifo_din, exp_din);
        else n_pass++;
      end
    end
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd4) $display("FAIL alt_count got=%0d want=4", count);
    else n_pass++;
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 9'h0C0 + 9'(i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (wren === 1'b1) begin
        n_checks++;
        exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
        if (fifo_din !== exp_din) $display("FAIL top_din%0d got=%h want=%h", i, fifo_din, exp_din);
        else n_pass++;
      end
    end
    step(1'b0, '0, 1'b1, 9'h1EE, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({rd_gnt, rden, wr_gnt1, wren} !== 4'b1100 || count !== 4'd8 || full !== 1'b1)
      $display("FAIL full_rw got=%b cnt=%0d want=1100 cnt=8", {rd_gnt, rden, wr_gnt1, wren}, count);
    else n_pass++;
    step(1'b0, '0, 1'b1, 9'h1EF, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({rd_gnt, wr_gnt1, rd_valid} !== 3'b111 || count !== 4'd7)
      $display("FAIL both_rw got=%b cnt=%0d want=111 cnt=7", {rd_gnt, wr_gnt1, rd_valid}, count);
    else n_pass++;
    if (wren === 1'b1) begin
      n_checks++;
      exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
      if (fifo_din !== exp_din) $display("FAIL both_din got=%h want=%h", fifo_din, exp_din);
      else n_pass++;
    end
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd7 || rd_valid !== 1'b1)
      $display("FAIL hold_count got cnt=%0d rv=%b want cnt=7 rv=1", count, rd_valid);
    else n_pass++;
  endtask

  task automatic test_empty_flush();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rd_gnt !== 1'b0 || rden !== 1'b0 || count !== 4'd0)
      $display("FAIL empty_rd got=%b cnt=%0d want=0 cnt=0", rd_gnt, count);
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL empty_rv got=%b want=0", rd_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 9'h150 + 9'(i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (wren === 1'b1) begin
        n_checks++;
        exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
        if (fifo_din !== exp_din) $display("FAIL five_din%0d got=%h want=%h", i, fifo_din, exp_din);
        else n_pass++;
      end
    end
    step(1'b1, 9'h155, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({wr_gnt0, wren} !== 2'b00 || count !== 4'd5)
      $display("FAIL flush_nogrant got=%b cnt=%0d want=00 cnt=5", {wr_gnt0, wren}, count);
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({WrPtrClr, RdPtrClr} !== 2'b11 || count !== 4'd0 || {WrPtrClr} !== e_clr)
      $display("FAIL flush_clear got=%b cnt=%0d want=11 cnt=0", {WrPtrClr, RdPtrClr}, count);
    else n_pass++;
    step(1'b1, 9'h1A5, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({WrPtrClr, RdPtrClr, wr_gnt0} !== 3'b001)
      $display("FAIL flush_resume got=%b want=001", {WrPtrClr, RdPtrClr, wr_gnt0});
    else n_pass++;
    if (wren === 1'b1) begin
      n_checks++;
      exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
      if (fifo_din !== exp_din) $display("FAIL resume_din got=%h want=%h", fifo_din, exp_din);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 9'h160 + 9'(i), 1'b0, 1'b0, 1'b0);
      if (wren === 1'b1) begin
        n_checks++;
        exp_din = (wq.size() != 0) ? wq.pop_front() : 9'hxxx;
        if (fifo_din !== exp_din) $display("FAIL six_din%0d got=%h want=%h", i, fifo_din, exp_din);
        else n_pass++;
      end
    end
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (rd_gnt !== 1'b1 || count !== 4'd6 || e_count != 6)
      $display("FAIL mid_read got=%b cnt=%0d want=1 cnt=6", rd_gnt, count);
    else n_pass++;
    step(1'b1, 9'h1CC, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({rd_gnt, wr_gnt0, wren, rd_valid} !== 4'b0001)
      $display("FAIL mid_rst got=%b want=0001", {rd_gnt, wr_gnt0, wren, rd_valid});
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || {WrPtrClr, RdPtrClr} !== 2'b11)
      $display("FAIL post_rst got cnt=%0d rv=%b clr=%b want cnt=0 rv=0 clr=11",
               count, rd_valid, {WrPtrClr, RdPtrClr});
    else n_pass++;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({WrPtrClr, RdPtrClr, empty, full} !== 4'b0010 || {empty, full} !== {e_empty, e_full})
      $display("FAIL back_run got=%b want=0010", {WrPtrClr, RdPtrClr, empty, full});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_single();
    test_alternate();
    test_full_rw();
    test_empty_flush();
    test_reset_mid();
    n_checks++;
    if (wq.size() != 0) $display("FAIL sb_leftover got=%0d want=0", wq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
